// File: rtl/calc_input_sequencer_if.sv
// rtl/calc_input_sequencer_if.sv - byte input and datapath control bundle for the calculator sequencer
interface calc_input_sequencer_if;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] charOut;
    logic       loadFirstSign;
    logic       loadFirstDigit;
    logic       loadSecondSign;
    logic       loadSecondDigit;
    logic       addNumbers;
    logic       displayAnswer;
    logic       ready;
    logic       error;
    logic       overrun;

    modport master (
        output rxData, rxValid,
        input  charOut, loadFirstSign, loadFirstDigit, loadSecondSign,
        input  loadSecondDigit, addNumbers, displayAnswer, ready, error, overrun
    );

    modport slave (
        input  rxData, rxValid,
        output charOut, loadFirstSign, loadFirstDigit, loadSecondSign,
        output loadSecondDigit, addNumbers, displayAnswer, ready, error, overrun
    );
endinterface

// File: rtl/calc_input_sequencer.sv
// rtl/calc_input_sequencer.sv - parses "<sign><hex>,<sign><hex>=" ASCII input into datapath load/strobe pulses
module calc_input_sequencer #(
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input logic                  CLK,
    input logic                  RESET,
    calc_input_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        S_SIGN1, S_DIG1, S_DIGS1,
        S_SIGN2, S_DIG2, S_DIGS2,
        S_ADD, S_DISP, S_ERROR
    } state_t;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       char_q, char_d;
    logic             fs_q, fs_d;
    logic             fd_q, fd_d;
    logic             ss_q, ss_d;
    logic             sd_q, sd_d;
    logic             overrun_q, overrun_d;
    logic             ready;
    logic             is_sign;
    logic             is_hex;

    assign ready   = (state_q != S_ADD) && (state_q != S_DISP);
    assign is_sign = (bus.rxData == CH_PLUS) || (bus.rxData == CH_MINUS);
    assign is_hex  = ((bus.rxData >= 8'h30) && (bus.rxData <= 8'h39)) ||
                     ((bus.rxData >= 8'h41) && (bus.rxData <= 8'h46)) ||
                     ((bus.rxData >= 8'h61) && (bus.rxData <= 8'h66));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_SIGN1;
            cnt_q     <= '0;
            char_q    <= 8'h00;
            fs_q      <= 1'b0;
            fd_q      <= 1'b0;
            ss_q      <= 1'b0;
            sd_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            char_q    <= char_d;
            fs_q      <= fs_d;
            fd_q      <= fd_d;
            ss_q      <= ss_d;
            sd_q      <= sd_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        char_d    = char_q;
        fs_d      = 1'b0;
        fd_d      = 1'b0;
        ss_d      = 1'b0;
        sd_d      = 1'b0;
        overrun_d = bus.rxValid && !ready;

        case (state_q)
            S_ADD:  state_d = S_DISP;
            S_DISP: state_d = S_SIGN1;
            S_ERROR: begin
                if (bus.rxValid && (bus.rxData == CH_CR)) begin
                    state_d = S_SIGN1;
                    cnt_d   = '0;
                    char_d  = bus.rxData;
                end
            end
            default: begin
                if (bus.rxValid) begin
                    char_d = bus.rxData;
                    if (bus.rxData == CH_CR) begin
                        state_d = S_SIGN1;
                        cnt_d   = '0;
                    end else begin
                        // Anything not matched below is illegal for this state.
                        state_d = S_ERROR;
                        case (state_q)
                            S_SIGN1: if (is_sign) begin
                                fs_d    = 1'b1;
                                cnt_d   = '0;
                                state_d = S_DIG1;
                            end
                            S_DIG1: if (is_hex) begin
                                fd_d    = 1'b1;
                                cnt_d   = cnt_q + CNT_W'(1);
                                state_d = S_DIGS1;
                            end
                            S_DIGS1: begin
                                if (is_hex && (cnt_q < MAX_CNT)) begin
                                    fd_d    = 1'b1;
                                    cnt_d   = cnt_q + CNT_W'(1);
                                    state_d = S_DIGS1;
                                end else if (bus.rxData == CH_COMMA) begin
                                    state_d = S_SIGN2;
                                end
                            end
                            S_SIGN2: if (is_sign) begin
                                ss_d    = 1'b1;
                                cnt_d   = '0;
                                state_d = S_DIG2;
                            end
                            S_DIG2: if (is_hex) begin
                                sd_d    = 1'b1;
                                cnt_d   = cnt_q + CNT_W'(1);
                                state_d = S_DIGS2;
                            end
                            S_DIGS2: begin
                                if (is_hex && (cnt_q < MAX_CNT)) begin
                                    sd_d    = 1'b1;
                                    cnt_d   = cnt_q + CNT_W'(1);
                                    state_d = S_DIGS2;
                                end else if (bus.rxData == CH_EQ) begin
                                    state_d = S_ADD;
                                end
                            end
                            default: state_d = S_ERROR;
                        endcase
                    end
                end
            end
        endcase
    end

    assign bus.charOut         = char_q;
    assign bus.loadFirstSign   = fs_q;
    assign bus.loadFirstDigit  = fd_q;
    assign bus.loadSecondSign  = ss_q;
    assign bus.loadSecondDigit = sd_q;
    assign bus.addNumbers      = (state_q == S_ADD);
    assign bus.displayAnswer   = (state_q == S_DISP);
    assign bus.ready           = ready;
    assign bus.error           = (state_q == S_ERROR);
    assign bus.overrun         = overrun_q;
endmodule

// File: tb/tb_calc_input_sequencer.sv
// tb/tb_calc_input_sequencer.sv - directed self-checking bench for calc_input_sequencer
module tb_calc_input_sequencer;
    localparam logic [5:0] NP = 6'b000000;
    localparam logic [5:0] FS = 6'b100000;
    localparam logic [5:0] FD = 6'b010000;
    localparam logic [5:0] SS = 6'b001000;
    localparam logic [5:0] SD = 6'b000100;
    localparam logic [5:0] AD = 6'b000010;
    localparam logic [5:0] DP = 6'b000001;
    localparam logic [7:0] CR = 8'h0D;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   tests = 0;
    int   failed = 0;

    calc_input_sequencer_if bus_if ();

    calc_input_sequencer dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus_if)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] pulses();
        return {bus_if.loadFirstSign, bus_if.loadFirstDigit, bus_if.loadSecondSign,
                bus_if.loadSecondDigit, bus_if.addNumbers, bus_if.displayAnswer};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
    endtask

    // One byte strobed for one cycle; checks land in the following cycle.
    task automatic send(input string tag, input logic [7:0] b, input logic [5:0] pv,
                        input bit chk_char, input bit exp_err);
        @(posedge CLK);
        #1;
        bus_if.rxData  = b;
        bus_if.rxValid = 1'b1;
        @(posedge CLK);
        #1;
        bus_if.rxValid = 1'b0;
        check({tag, ".pulses"}, 32'(pulses()), 32'(pv));
        check({tag, ".error"}, 32'(bus_if.error), 32'(exp_err));
        if (chk_char) check({tag, ".char"}, 32'(bus_if.charOut), 32'(b));
    endtask

    task automatic send_ok(input string tag, input string s, input logic [5:0] pv_list [$]);
        for (int i = 0; i < s.len(); i++) begin
            send($sformatf("%s[%0d]", tag, i), s[i], pv_list[i], 1'b1, 1'b0);
        end
    endtask

    task automatic finish_calc(input string tag);
        check({tag, ".ready_add"}, 32'(bus_if.ready), 32'h0);
        idle();
        check({tag, ".disp"}, 32'(pulses()), 32'(DP));
        check({tag, ".ready_disp"}, 32'(bus_if.ready), 32'h0);
        idle();
        check({tag, ".idle"}, 32'(pulses()), 32'(NP));
        check({tag, ".ready_back"}, 32'(bus_if.ready), 32'h1);
    endtask

    initial begin
        bus_if.rxData  = 8'h00;
        bus_if.rxValid = 1'b0;
        #12;
        check("rst.char", 32'(bus_if.charOut), 32'h0);
        check("rst.pulses", 32'(pulses()), 32'(NP));
        check("rst.ready", 32'(bus_if.ready), 32'h1);
        check("rst.error", 32'(bus_if.error), 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // 1: basic expression
        send_ok("t1", "+1A,-F=", '{FS, FD, FD, NP, SS, SD, AD});
        finish_calc("t1");

        // 2: maximum digit count on both operands
        send_ok("t2", "+1234,+0001=", '{FS, FD, FD, FD, FD, NP, SS, SD, SD, SD, SD, AD});
        finish_calc("t2");

        // 3: digit overflow, sticky error, CR recovery
        send_ok("t3", "+1234", '{FS, FD, FD, FD, FD});
        send("t3.fifth", "5", NP, 1'b1, 1'b1);
        send("t3.ign1", "6", NP, 1'b0, 1'b1);
        send("t3.ign2", "=", NP, 1'b0, 1'b1);
        send("t3.cr", CR, NP, 1'b0, 1'b0);
        send_ok("t3b", "+1,+1=", '{FS, FD, NP, SS, SD, AD});
        finish_calc("t3b");

        // 4: illegal bytes in various states
        send_ok("t4a", "+", '{FS});
        send("t4a.G", "G", NP, 1'b1, 1'b1);
        send("t4a.cr", CR, NP, 1'b0, 1'b0);
        send_ok("t4b", "+", '{FS});
        send("t4b.comma", ",", NP, 1'b1, 1'b1);
        send("t4b.cr", CR, NP, 1'b0, 1'b0);
        send_ok("t4c", "+1,", '{FS, FD, NP});
        send("t4c.eq", "=", NP, 1'b1, 1'b1);
        send("t4c.cr", CR, NP, 1'b0, 1'b0);
        send("t4d.digit", "1", NP, 1'b1, 1'b1);
        send("t4d.cr", CR, NP, 1'b0, 1'b0);
        send_ok("t4e", "+a,-f=", '{FS, FD, NP, SS, SD, AD});
        finish_calc("t4e");

        // 5: strobe held into ADD -> dropped byte and overrun
        send_ok("t5", "+2,+3", '{FS, FD, NP, SS, SD});
        @(posedge CLK);
        #1;
        bus_if.rxData  = "=";
        bus_if.rxValid = 1'b1;
        @(posedge CLK);
        #1;
        bus_if.rxData  = "+";
        check("t5.add", 32'(pulses()), 32'(AD));
        check("t5.ready_add", 32'(bus_if.ready), 32'h0);
        check("t5.ovr_none", 32'(bus_if.overrun), 32'h0);
        @(posedge CLK);
        #1;
        bus_if.rxValid = 1'b0;
        check("t5.disp", 32'(pulses()), 32'(DP));
        check("t5.overrun", 32'(bus_if.overrun), 32'h1);
        check("t5.char_kept", 32'(bus_if.charOut), 32'h3D);
        @(posedge CLK);
        #1;
        check("t5.idle", 32'(pulses()), 32'(NP));
        check("t5.ovr_once", 32'(bus_if.overrun), 32'h0);
        check("t5.ready", 32'(bus_if.ready), 32'h1);
        check("t5.error", 32'(bus_if.error), 32'h0);
        send_ok("t5b", "+1,+1=", '{FS, FD, NP, SS, SD, AD});
        finish_calc("t5b");

        // 6: asynchronous reset mid-entry, then CR mid-entry
        send_ok("t6", "+12,-", '{FS, FD, FD, NP, SS});
        RESET = 1'b1;
        #1;
        check("t6.rst_char", 32'(bus_if.charOut), 32'h0);
        check("t6.rst_pulses", 32'(pulses()), 32'(NP));
        check("t6.rst_ready", 32'(bus_if.ready), 32'h1);
        check("t6.rst_error", 32'(bus_if.error), 32'h0);
        @(posedge CLK);
        #1;
        check("t6.rst_hold", 32'(pulses()), 32'(NP));
        RESET = 1'b0;
        send_ok("t6b", "+3,+4=", '{FS, FD, NP, SS, SD, AD});
        finish_calc("t6b");
        send_ok("t6c", "+5,-6", '{FS, FD, NP, SS, SD});
        send("t6c.cr", CR, NP, 1'b1, 1'b0);
        send_ok("t6d", "-7", '{FS, FD});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
